arm: RTL and testbench
======================

ARM -- requirements
Module: arm

Interface
REQ-001 SHALL have parameter INS_MEM_SIZE, default 32, instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter DATA_MEM_SIZE, default 64, data-memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have no other ports.
REQ-006 SHALL expose these hierarchical names for bench access:
- pc: 32-bit program counter.
- instruction: 32-bit current word.
- reg_write: register-file write enable.
- nzcv_n: 4-bit next-flags value.
- _ins_mem.mem: word array [0:INS_MEM_SIZE-1].
- _data_mem.mem: word array [0:DATA_MEM_SIZE-1].
- _data_mem.mem_write, _data_mem.addr, _data_mem.write_data.
- _register_file.write_addr, _register_file.write_data.

Function
REQ-007 SHALL be single-cycle: each rising clk retires exactly one instruction (register, flag, memory and pc updates together).
REQ-008 SHALL read instructions combinationally: instruction = _ins_mem.mem[pc[6:2]]; instruction memory never written by hardware.
REQ-009 SHALL update pc to pc+4 each cycle unless a taken branch; reads of r15 as an operand SHALL return pc+8.
REQ-010 SHALL evaluate condition field [31:28] against flags register NZCV for all 15 ARM codes (EQ..AL); failed condition SHALL suppress register, flag and memory writes; pc advances by 4.
REQ-011 SHALL support data processing ([27:26]=00): AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN; 32-bit wrap-around arithmetic.
REQ-012 Operand2 SHALL be either imm8 rotated right by 2*rot4 (I=1) or Rm shifted by imm5 with LSL/LSR/ASR/ROR (I=0); LSR/ASR #0 mean #32; ROR #0 means RRX.
REQ-013 S=1 SHALL update N=result[31], Z=(result==0); arithmetic ops set C (carry out; borrow-inverted for subtracts) and V (signed overflow); logical ops set C from shifter carry-out, V unchanged.
REQ-014 TST/TEQ/CMP/CMN SHALL update flags only, never write Rd.
REQ-015 SHALL support LDR/STR word ([27:26]=01): 12-bit immediate offset, U selects add/subtract, pre-indexed, no writeback; byte and register-offset forms are out of scope and act as NOPs.
REQ-016 Data-memory address: byte address Rn±offset; word index = addr[7:2]; STR writes Rd at rising clk when mem_write=1; LDR reads combinationally and writes Rd.
REQ-017 SHALL support B/BL ([27:25]=101): target = pc+8+sign_extend(imm24)<<2; BL writes pc+4 to r14.
REQ-018 Writes to r15 by data-processing or LDR SHALL load pc with the result.
REQ-019 nzcv_n SHALL equal the value the flags register takes at the next rising clk.
REQ-020 Undefined encodings SHALL act as NOPs.
REQ-021 Register file: 16x32, two combinational reads plus a third for STR data; one synchronous write port, enabled by reg_write.

Reset
REQ-022 rst high SHALL asynchronously clear pc, NZCV and r0-r14 to 0; reg_write and mem_write SHALL be 0 while rst high.
REQ-023 Reset SHALL NOT clear or initialize either memory; contents loaded by the bench persist.
REQ-024 Execution SHALL start at pc=0 on the first rising clk after rst falls; reset mid-run SHALL restart from pc=0 with memories intact.

Verification
REQ-025 Reset, MOV r1,#5; ADD r2,r1,#3 -> r2=8, pc=8 after two cycles.
REQ-026 MOV r0,#0x10; MOV r1,#0xAB; STR r1,[r0,#4] -> _data_mem.mem[5]=0x000000AB; LDR r2,[r0,#4] -> r2=0xAB.
REQ-027 MOV r0,#1; SUBS r1,r0,#1 -> NZCV=0110, r1=0; BEQ +8 skips the next two instructions.
REQ-028 MVN r0,#0 then ADDS r1,r0,#1 -> r1=0, NZCV=0110; ADDS with 0x7FFFFFFF+1 -> V=1, N=1.
REQ-029 Condition-failed STRNE with Z=1 -> no data-memory change; run to pc>=128 -> data memory matches expected image exactly (0 mismatches over 64 words).
REQ-030 BL at pc=0x10 to 0x40 -> r14=0x14, pc=0x40; MOV pc,lr -> pc=0x14.

Source files
------------

// File: rtl/arm.sv
// Single-cycle ARM subset core: data processing, LDR/STR word, B/BL.
// Instruction and data memories are plain word arrays loaded from outside; reset never touches them.

module arm_ins_mem #(
   parameter int INS_MEM_SIZE = 32
) (
   input  logic [31:0] i_addr,
   output logic [31:0] o_rdata
);
   localparam int AW = $clog2(INS_MEM_SIZE);

   logic [31:0]   mem [0:INS_MEM_SIZE-1];
   logic [AW-1:0] w_idx;
   logic          w_unused;

   assign w_idx    = i_addr[AW+1:2];
   assign w_unused = &{1'b0, i_addr[31:AW+2], i_addr[1:0]};
   assign o_rdata  = mem[w_idx];
endmodule

module arm_data_mem #(
   parameter int DATA_MEM_SIZE = 64
) (
   input  logic        clk,
   input  logic        i_mem_write,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_write_data,
   output logic [31:0] o_read_data
);
   localparam int AW = $clog2(DATA_MEM_SIZE);

   logic [31:0]   mem [0:DATA_MEM_SIZE-1];
   logic          mem_write;
   logic [31:0]   addr;
   logic [31:0]   write_data;
   logic [AW-1:0] w_idx;
   logic          w_unused;

   assign mem_write  = i_mem_write;
   assign addr       = i_addr;
   assign write_data = i_write_data;
   assign w_idx      = addr[AW+1:2];
   assign w_unused   = &{1'b0, addr[31:AW+2], addr[1:0]};

   always_ff @(posedge clk) begin
      if (mem_write) mem[w_idx] <= write_data;
   end

   assign o_read_data = mem[w_idx];
endmodule

module arm_register_file (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_reg_write,
   input  logic [3:0]  i_read_addr1,
   input  logic [3:0]  i_read_addr2,
   input  logic [3:0]  i_read_addr3,
   input  logic [3:0]  i_write_addr,
   input  logic [31:0] i_write_data,
   output logic [31:0] o_read_data1,
   output logic [31:0] o_read_data2,
   output logic [31:0] o_read_data3
);
   logic [31:0] r_regs [0:15];
   logic [3:0]  write_addr;
   logic [31:0] write_data;

   assign write_addr = i_write_addr;
   assign write_data = i_write_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) r_regs[i[3:0]] <= '0;
      end else if (i_reg_write) begin
         r_regs[write_addr] <= write_data;
      end
   end

   assign o_read_data1 = r_regs[i_read_addr1];
   assign o_read_data2 = r_regs[i_read_addr2];
   assign o_read_data3 = r_regs[i_read_addr3];
endmodule

module arm #(
   parameter int INS_MEM_SIZE  = 32,
   parameter int DATA_MEM_SIZE = 64
) (
   input  logic clk,
   input  logic rst
);
   localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE;

   logic [31:0] pc;
   logic [31:0] instruction;
   logic        reg_write;
   logic [3:0]  nzcv_n;
   logic [3:0]  r_nzcv;

   logic [31:0] w_pc_plus4, w_pc_plus8, w_pc_next;
   logic [31:0] w_rd1, w_rd2, w_rd3, w_rn_val, w_rm_val, w_rd_val;
   logic [3:0]  w_rn, w_rm, w_rd, w_opcode;
   logic        w_cond_ok, w_is_dp, w_is_mem, w_is_br, w_is_test;
   logic [32:0] w_op2;
   logic [35:0] w_alu;
   logic [31:0] w_mem_addr, w_mem_rdata, w_br_target;
   logic        w_wr_en, w_mem_wr, mem_write;
   logic [3:0]  w_wr_addr;
   logic [31:0] w_wr_data;

   function automatic logic f_cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Returns {carry_out, value}; immediate shift amount 0 encodes #32 for LSR/ASR and RRX for ROR.
   function automatic logic [32:0] f_shift(input logic [31:0] v, input logic [1:0] typ,
                                           input logic [4:0] imm5, input logic cin);
      logic [5:0]         sh;
      logic [32:0]        t;
      logic signed [32:0] s;
      logic [63:0]        r;
      sh = (imm5 == 5'd0 && (typ == 2'b01 || typ == 2'b10)) ? 6'd32 : {1'b0, imm5};
      t  = '0;
      s  = '0;
      r  = '0;
      case (typ)
         2'b00: begin
            t = {1'b0, v} << sh;
            return (sh == 6'd0) ? {cin, v} : t;
         end
         2'b01: begin
            t = {v, 1'b0} >> sh;
            return {t[0], t[32:1]};
         end
         2'b10: begin
            s = {v, 1'b0};
            s = s >>> sh;
            return {s[0], s[32:1]};
         end
         default: begin
            if (sh == 6'd0) return {v[0], cin, v[31:1]};
            r = {v, v} >> sh;
            return {r[31], r[31:0]};
         end
      endcase
   endfunction

   function automatic logic [32:0] f_rot_imm(input logic [11:0] imm12, input logic cin);
      logic [63:0] r;
      r = {24'd0, imm12[7:0], 24'd0, imm12[7:0]} >> {imm12[11:8], 1'b0};
      return {(imm12[11:8] == 4'd0) ? cin : r[31], r[31:0]};
   endfunction

   // Returns {N, Z, C, V, result}.
   function automatic logic [35:0] f_alu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [3:0] f,
                                         input logic sh_c);
      logic [31:0] x, y, res;
      logic        ci, arith, c, v;
      logic [32:0] sum;
      x = a; y = b; ci = 1'b0; arith = 1'b1;
      res = '0;
      case (op)
         OP_SUB, OP_CMP: begin y = ~b; ci = 1'b1; end
         OP_RSB:         begin x = b; y = ~a; ci = 1'b1; end
         OP_ADD, OP_CMN: ci = 1'b0;
         OP_ADC:         ci = f[1];
         OP_SBC:         begin y = ~b; ci = f[1]; end
         OP_RSC:         begin x = b; y = ~a; ci = f[1]; end
         default:        arith = 1'b0;
      endcase
      sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      case (op)
         OP_AND, OP_TST: res = a & b;
         OP_EOR, OP_TEQ: res = a ^ b;
         OP_ORR:         res = a | b;
         OP_MOV:         res = b;
         OP_BIC:         res = a & ~b;
         4'hF:           res = ~b;
         default:        res = sum[31:0];
      endcase
      c = arith ? sum[32] : sh_c;
      v = arith ? ((x[31] == y[31]) && (res[31] != x[31])) : f[0];
      return {res[31], res == 32'd0, c, v, res};
   endfunction

   arm_ins_mem #(.INS_MEM_SIZE(INS_MEM_SIZE)) _ins_mem (
      .i_addr  (pc),
      .o_rdata (instruction)
   );

   assign w_rn     = instruction[19:16];
   assign w_rd     = instruction[15:12];
   assign w_rm     = instruction[3:0];
   assign w_opcode = instruction[24:21];

   arm_register_file _register_file (
      .clk          (clk),
      .rst          (rst),
      .i_reg_write  (reg_write),
      .i_read_addr1 (w_rn),
      .i_read_addr2 (w_rm),
      .i_read_addr3 (w_rd),
      .i_write_addr (w_wr_addr),
      .i_write_data (w_wr_data),
      .o_read_data1 (w_rd1),
      .o_read_data2 (w_rd2),
      .o_read_data3 (w_rd3)
   );

   // r15 is never stored; operand reads see the pipeline-visible pc+8.
   assign w_pc_plus4 = pc + 32'd4;
   assign w_pc_plus8 = pc + 32'd8;
   assign w_rn_val   = (w_rn == 4'd15) ? w_pc_plus8 : w_rd1;
   assign w_rm_val   = (w_rm == 4'd15) ? w_pc_plus8 : w_rd2;
   assign w_rd_val   = (w_rd == 4'd15) ? w_pc_plus8 : w_rd3;

   assign w_cond_ok = f_cond_pass(instruction[31:28], r_nzcv);
   assign w_is_dp   = (instruction[27:26] == 2'b00) && (instruction[25] || !instruction[4]) &&
                      !(instruction[24:23] == 2'b10 && !instruction[20]);
   assign w_is_test = (instruction[24:23] == 2'b10);
   assign w_is_mem  = (instruction[27:26] == 2'b01) && !instruction[25] && instruction[24] &&
                      !instruction[22] && !instruction[21];
   assign w_is_br   = (instruction[27:25] == 3'b101);

   assign w_op2 = instruction[25] ? f_rot_imm(instruction[11:0], r_nzcv[1])
                                  : f_shift(w_rm_val, instruction[6:5], instruction[11:7], r_nzcv[1]);
   assign w_alu = f_alu(w_opcode, w_rn_val, w_op2[31:0], r_nzcv, w_op2[32]);

   assign w_mem_addr  = instruction[23] ? (w_rn_val + {20'd0, instruction[11:0]})
                                        : (w_rn_val - {20'd0, instruction[11:0]});
   assign w_br_target = w_pc_plus8 + {{6{instruction[23]}}, instruction[23:0], 2'b00};

   arm_data_mem #(.DATA_MEM_SIZE(DATA_MEM_SIZE)) _data_mem (
      .clk          (clk),
      .i_mem_write  (mem_write),
      .i_addr       (w_mem_addr),
      .i_write_data (w_rd_val),
      .o_read_data  (w_mem_rdata)
   );

   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = w_rd;
      w_wr_data = w_alu[31:0];
      w_mem_wr  = 1'b0;
      w_pc_next = w_pc_plus4;
      nzcv_n    = r_nzcv;
      if (w_cond_ok) begin
         if (w_is_dp) begin
            if (instruction[20]) nzcv_n = w_alu[35:32];
            if (!w_is_test) begin
               if (w_rd == 4'd15) w_pc_next = w_alu[31:0];
               else               w_wr_en   = 1'b1;
            end
         end else if (w_is_mem) begin
            if (instruction[20]) begin
               w_wr_data = w_mem_rdata;
               if (w_rd == 4'd15) w_pc_next = w_mem_rdata;
               else               w_wr_en   = 1'b1;
            end else begin
               w_mem_wr = 1'b1;
            end
         end else if (w_is_br) begin
            w_pc_next = w_br_target;
            if (instruction[24]) begin
               w_wr_en   = 1'b1;
               w_wr_addr = 4'd14;
               w_wr_data = w_pc_plus4;
            end
         end
      end
   end

   assign reg_write = w_wr_en && !rst;
   assign mem_write = w_mem_wr && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= '0;
         r_nzcv <= '0;
      end else begin
         pc     <= w_pc_next;
         r_nzcv <= nzcv_n;
      end
   end
endmodule

// File: tb/tb_arm.sv
// Directed bench for the single-cycle ARM core: hand-assembled programs with hand-computed results.

module tb_arm;
   localparam logic [31:0] NOP = 32'hE320F000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc;
   int   mism;
   logic [31:0] exp_img [0:63];

   arm #(.INS_MEM_SIZE(32), .DATA_MEM_SIZE(64)) dut (
      .clk (clk),
      .rst (rst)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ld(input logic [4:0] idx, input logic [31:0] w);
      dut._ins_mem.mem[idx] = w;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 32; i++) dut._ins_mem.mem[i] = NOP;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) dut._data_mem.mem[i] = 32'd0;

      // MOV r1,#5 ; ADD r2,r1,#3
      hold_reset();
      ld(0, 32'hE3A01005);
      ld(1, 32'hE2812003);
      #1;
      chk("rst_pc", dut.pc, 32'd0);
      chk("rst_reg_write", {31'd0, dut.reg_write}, 32'd0);
      chk("rst_mem_write", {31'd0, dut._data_mem.mem_write}, 32'd0);
      release_reset();
      chk("mov_instr", dut.instruction, 32'hE3A01005);
      chk("mov_wr_addr", {28'd0, dut._register_file.write_addr}, 32'd1);
      chk("mov_wr_data", dut._register_file.write_data, 32'd5);
      step();
      chk("add_pc", dut.pc, 32'd4);
      chk("add_wr_addr", {28'd0, dut._register_file.write_addr}, 32'd2);
      chk("add_wr_data", dut._register_file.write_data, 32'd8);
      step();
      chk("two_cycle_pc", dut.pc, 32'd8);

      // STR r1,[r0,#4] / LDR r2,[r0,#4]
      hold_reset();
      ld(0, 32'hE3A00010);
      ld(1, 32'hE3A010AB);
      ld(2, 32'hE5801004);
      ld(3, 32'hE5902004);
      release_reset();
      step();
      step();
      chk("str_mem_write", {31'd0, dut._data_mem.mem_write}, 32'd1);
      chk("str_addr", dut._data_mem.addr, 32'h14);
      chk("str_data", dut._data_mem.write_data, 32'hAB);
      step();
      chk("str_mem5", dut._data_mem.mem[5], 32'h000000AB);
      chk("ldr_reg_write", {31'd0, dut.reg_write}, 32'd1);
      chk("ldr_wr_addr", {28'd0, dut._register_file.write_addr}, 32'd2);
      chk("ldr_wr_data", dut._register_file.write_data, 32'hAB);

      // SUBS sets Z, BEQ +8 skips two instructions
      hold_reset();
      ld(0, 32'hE3A00001);
      ld(1, 32'hE2501001);
      ld(2, 32'h0A000001);
      ld(3, 32'hE3A030EE);
      ld(4, 32'hE3A030EE);
      ld(5, 32'hE3A04044);
      release_reset();
      step();
      chk("subs_nzcv", {28'd0, dut.nzcv_n}, 32'h6);
      chk("subs_result", dut._register_file.write_data, 32'd0);
      step();
      step();
      chk("beq_pc", dut.pc, 32'h14);
      chk("beq_land_addr", {28'd0, dut._register_file.write_addr}, 32'd4);
      chk("beq_land_data", dut._register_file.write_data, 32'h44);

      // MVN / ADDS carry and overflow, shifter forms
      hold_reset();
      ld(0, 32'hE3E00000);
      ld(1, 32'hE2901001);
      ld(2, 32'hE3E02102);
      ld(3, 32'hE2923001);
      ld(4, 32'hE1B05200);
      ld(5, 32'hE1A06043);
      release_reset();
      chk("mvn_data", dut._register_file.write_data, 32'hFFFFFFFF);
      step();
      chk("adds_wrap_nzcv", {28'd0, dut.nzcv_n}, 32'h6);
      chk("adds_wrap_data", dut._register_file.write_data, 32'd0);
      step();
      chk("mvn_rot_data", dut._register_file.write_data, 32'h7FFFFFFF);
      step();
      chk("adds_ovf_nzcv", {28'd0, dut.nzcv_n}, 32'h9);
      chk("adds_ovf_data", dut._register_file.write_data, 32'h80000000);
      step();
      chk("movs_lsl_data", dut._register_file.write_data, 32'hFFFFFFF0);
      chk("movs_lsl_nzcv", {28'd0, dut.nzcv_n}, 32'hB);
      step();
      chk("asr32_data", dut._register_file.write_data, 32'hFFFFFFFF);

      // Condition-failed STRNE, then run to pc>=128 and compare the data image
      hold_reset();
      for (int i = 0; i < 64; i++) begin
         dut._data_mem.mem[i] = 32'd0;
         exp_img[i] = 32'd0;
      end
      exp_img[8] = 32'h55;
      exp_img[6] = 32'h55;
      ld(0, 32'hE3A00020);
      ld(1, 32'hE3A01055);
      ld(2, 32'hE5801000);
      ld(3, 32'hE0502000);
      ld(4, 32'h15801004);
      ld(5, 32'hE5001008);
      release_reset();
      step();
      step();
      step();
      chk("subs_zero_nzcv", {28'd0, dut.nzcv_n}, 32'h6);
      step();
      chk("strne_mem_write", {31'd0, dut._data_mem.mem_write}, 32'd0);
      step();
      chk("str_neg_addr", dut._data_mem.addr, 32'h18);
      cyc = 0;
      while (dut.pc < 32'd128 && cyc < 200) begin
         step();
         cyc++;
      end
      chk("run_bound", {31'd0, dut.pc >= 32'd128}, 32'd1);
      mism = 0;
      for (int i = 0; i < 64; i++) if (dut._data_mem.mem[i] !== exp_img[i]) mism++;
      chk("dmem_image_mismatches", mism, 32'd0);

      // Asynchronous reset mid-run keeps memory
      rst = 1'b1;
      #1;
      chk("async_rst_pc", dut.pc, 32'd0);
      chk("async_rst_reg_write", {31'd0, dut.reg_write}, 32'd0);
      chk("rst_keeps_dmem", dut._data_mem.mem[8], 32'h55);

      // BL at 0x10 to 0x40, r15 operand read, MOV pc,lr
      hold_reset();
      ld(4, 32'hEB00000A);
      ld(5, 32'hE28F7000);
      ld(16, 32'hE1A0F00E);
      release_reset();
      step();
      step();
      step();
      step();
      chk("bl_pc", dut.pc, 32'h10);
      chk("bl_wr_addr", {28'd0, dut._register_file.write_addr}, 32'd14);
      chk("bl_wr_data", dut._register_file.write_data, 32'h14);
      step();
      chk("bl_target_pc", dut.pc, 32'h40);
      chk("mov_pc_no_reg_write", {31'd0, dut.reg_write}, 32'd0);
      step();
      chk("mov_pc_lr", dut.pc, 32'h14);
      chk("pc_plus8_addr", {28'd0, dut._register_file.write_addr}, 32'd7);
      chk("pc_plus8_data", dut._register_file.write_data, 32'h1C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
